// File: rtl/vga_game_pkg.sv
// Shared definitions for the VGA game blocks.
// Contents:
//   DEF_SCREEN_H / DEF_PADDLE_H / DEF_Y_W : default geometry of the playfield
//   dir_t                                 : paddle motion direction
//   centre_y()                            : top line of a vertically centred paddle
//   PADDLE_Y_RST                          : centred paddle position for the default geometry
package vga_game_pkg;

    localparam int unsigned DEF_SCREEN_H = 480;
    localparam int unsigned DEF_PADDLE_H = 64;
    localparam int unsigned DEF_Y_W      = 10;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    function automatic int unsigned centre_y(input int unsigned screen_h,
                                             input int unsigned paddle_h);
        return (screen_h - paddle_h) / 2;
    endfunction

    localparam int unsigned PADDLE_Y_RST = centre_y(DEF_SCREEN_H, DEF_PADDLE_H);

endpackage

// File: rtl/paddle_controller_if.sv
// Player-side bundle of one paddle controller.
// Signals:
//   frame_tick : 1-cycle pulse per frame from the sync generator
//   but_up     : raw asynchronous up button (active high)
//   but_down   : raw asynchronous down button (active high)
//   up_db      : debounced up level
//   down_db    : debounced down level
//   paddle_y   : top line of the paddle
// Modports:
//   master : drives tick and buttons, observes the paddle (game top / bench)
//   slave  : the paddle controller itself
interface paddle_controller_if #(
    parameter int unsigned Y_W = 10
) ();

    logic           frame_tick;
    logic           but_up;
    logic           but_down;
    logic           up_db;
    logic           down_db;
    logic [Y_W-1:0] paddle_y;

    modport master (
        output frame_tick,
        output but_up,
        output but_down,
        input  up_db,
        input  down_db,
        input  paddle_y
    );

    modport slave (
        input  frame_tick,
        input  but_up,
        input  but_down,
        output up_db,
        output down_db,
        output paddle_y
    );

endinterface

// File: rtl/paddle_controller_button_debouncer.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
// The debounced level only follows the synchronised level after it has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   i_btn : raw asynchronous button level
//   o_db  : debounced level
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_db
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            w_db_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_db    <= w_db_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Any cycle where the synced level agrees with the output restarts the count,
    // so only an unbroken run of disagreement can flip the output.
    always_comb begin
        w_cnt_d = r_cnt;
        w_db_d  = r_db;
        if (r_sync2 == r_db) begin
            w_cnt_d = '0;
        end else if (r_cnt == CntMax) begin
            w_cnt_d = '0;
            w_db_d  = ~r_db;
        end else begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/paddle_controller.sv
// One player's paddle: debounces the up/down buttons and moves the paddle
// once per frame, clamped to [0, SCREEN_H-PADDLE_H].
// Optional feature macro: PADDLE_ACCEL_EN -- when defined, the step grows by 1
// after every ACCEL_FRAMES consecutive ticks in the same direction (capped at
// MAX_STEP); otherwise the step is the constant STEP.
// Ports:
//   clk : pixel clock
//   rst : synchronous active-high reset
//   bus : slave side of paddle_controller_if
//         (frame_tick, but_up, but_down in; up_db, down_db, paddle_y out)
module paddle_controller
    import vga_game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SCREEN_H        = DEF_SCREEN_H,
    parameter int unsigned PADDLE_H        = DEF_PADDLE_H,
    parameter int unsigned STEP            = 4,
    parameter int unsigned MAX_STEP        = 12,
    parameter int unsigned ACCEL_FRAMES    = 8,
    parameter int unsigned Y_W             = DEF_Y_W
) (
    input logic                clk,
    input logic                rst,
    paddle_controller_if.slave bus
);

    localparam int unsigned YMax = SCREEN_H - PADDLE_H;
    localparam int unsigned YRst = centre_y(SCREEN_H, PADDLE_H);
    // One spare bit so y+step and the y<step compare cannot wrap.
    localparam int unsigned AW   = Y_W + 1;

    if (ACCEL_FRAMES == 0 || MAX_STEP < STEP || PADDLE_H > SCREEN_H) begin : g_cfg_check
        $error("paddle_controller: inconsistent parameter set");
    end

    logic           w_up_db;
    logic           w_down_db;
    dir_t           w_dir;
    logic [AW-1:0]  w_step;
    logic [AW-1:0]  w_y_ext;
    logic [AW-1:0]  w_sum;
    logic [Y_W-1:0] r_y;
    logic [Y_W-1:0] w_y_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .i_btn (bus.but_up),
        .o_db  (w_up_db)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_down (
        .clk   (clk),
        .rst   (rst),
        .i_btn (bus.but_down),
        .o_db  (w_down_db)
    );

    // Both held cancels out.
    always_comb begin
        w_dir = DIR_NONE;
        if (w_up_db && !w_down_db) begin
            w_dir = DIR_UP;
        end else if (w_down_db && !w_up_db) begin
            w_dir = DIR_DOWN;
        end
    end

`ifdef PADDLE_ACCEL_EN
    localparam int unsigned HW = $clog2(ACCEL_FRAMES + 1);

    dir_t          r_last_dir;
    dir_t          w_last_dir_d;
    logic [AW-1:0] r_step;
    logic [AW-1:0] w_step_d;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_d;
    logic [HW-1:0] w_hold_base;
    logic [HW-1:0] w_hold_inc;
    logic          w_new_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_dir <= DIR_NONE;
            r_step     <= AW'(STEP);
            r_hold     <= '0;
        end else begin
            r_last_dir <= w_last_dir_d;
            r_step     <= w_step_d;
            r_hold     <= w_hold_d;
        end
    end

    // A tick that starts a new run (idle or direction change) moves by STEP;
    // r_step/r_hold describe the run as of the previous tick.
    always_comb begin
        w_new_run    = (w_dir == DIR_NONE) || (w_dir != r_last_dir);
        w_step       = w_new_run ? AW'(STEP) : r_step;
        w_hold_base  = w_new_run ? '0 : r_hold;
        w_hold_inc   = w_hold_base + 1'b1;
        w_last_dir_d = r_last_dir;
        w_step_d     = r_step;
        w_hold_d     = r_hold;
        if (bus.frame_tick) begin
            w_last_dir_d = w_dir;
            if (w_dir == DIR_NONE) begin
                w_step_d = AW'(STEP);
                w_hold_d = '0;
            end else if (w_hold_inc >= HW'(ACCEL_FRAMES)) begin
                w_hold_d = '0;
                w_step_d = (w_step < AW'(MAX_STEP)) ? w_step + 1'b1 : w_step;
            end else begin
                w_hold_d = w_hold_inc;
                w_step_d = w_step;
            end
        end
    end
`else
    assign w_step = AW'(STEP);
`endif

    always_comb begin
        w_y_ext = {1'b0, r_y};
        w_sum   = w_y_ext + w_step;
        w_y_d   = r_y;
        if (bus.frame_tick) begin
            unique case (w_dir)
                DIR_UP:   w_y_d = (w_y_ext < w_step) ? '0 : Y_W'(w_y_ext - w_step);
                DIR_DOWN: w_y_d = (w_sum > AW'(YMax)) ? Y_W'(YMax) : Y_W'(w_sum);
                default:  w_y_d = r_y;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= Y_W'(YRst);
        end else begin
            r_y <= w_y_d;
        end
    end

    assign bus.up_db    = w_up_db;
    assign bus.down_db  = w_down_db;
    assign bus.paddle_y = r_y;

endmodule

// File: tb/tb_paddle_controller.sv
// Self-checking bench for paddle_controller (DEBOUNCE_CYCLES=4, tick every 20 clk).
module tb_paddle_controller;

    localparam int DC           = 4;
    localparam int TICK_PERIOD  = 20;
    localparam int STEP         = 4;
    localparam int MAX_STEP     = 12;
    localparam int ACCEL_FRAMES = 8;
    localparam int YMAX         = 416;
    localparam int YRST         = 208;

    logic clk = 1'b0;
    logic rst;

    paddle_controller_if #(.Y_W(10)) bus ();

    paddle_controller #(
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tick_phase = 0;
    always @(negedge clk) begin
        tick_phase     = (tick_phase + 1) % TICK_PERIOD;
        bus.frame_tick = (tick_phase == 0);
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: buttons are seen two cycles late, and a debounced level
    // flips after DC consecutive cycles of disagreement. Motion uses the
    // debounced levels held before the tick edge.
    bit model_valid = 0;
    bit chk_en      = 0;
    int m_y;
    bit m_db[2];
    int m_run[2];
    bit m_hist[2][2];
`ifdef PADDLE_ACCEL_EN
    int m_last;
    int m_held;
`endif

    always @(posedge clk) begin
        bit raw[2];
        bit view;
        int d;
        int step;
        raw[0] = bus.but_up;
        raw[1] = bus.but_down;
        if (rst) begin
            m_y = YRST;
            for (int b = 0; b < 2; b++) begin
                m_db[b]      = 0;
                m_run[b]     = 0;
                m_hist[b][0] = 0;
                m_hist[b][1] = 0;
            end
`ifdef PADDLE_ACCEL_EN
            m_last = 0;
            m_held = 0;
`endif
            model_valid = 1;
        end else if (model_valid) begin
            if (bus.frame_tick) begin
                d = (m_db[0] && !m_db[1]) ? 1 : ((m_db[1] && !m_db[0]) ? 2 : 0);
                step = STEP;
`ifdef PADDLE_ACCEL_EN
                if (d == 0 || d != m_last) m_held = 0;
                step = STEP + m_held / ACCEL_FRAMES;
                if (step > MAX_STEP) step = MAX_STEP;
                if (d != 0) m_held++;
                m_last = d;
`endif
                if (d == 1) m_y = (m_y < step) ? 0 : m_y - step;
                else if (d == 2) m_y = (m_y + step > YMAX) ? YMAX : m_y + step;
            end
            for (int b = 0; b < 2; b++) begin
                view = m_hist[b][0];
                m_hist[b][0] = m_hist[b][1];
                m_hist[b][1] = raw[b];
                if (view != m_db[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DC) begin
                        m_db[b]  = ~m_db[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
        #1;
        if (model_valid && chk_en) begin
            check("model_up_db", int'(bus.up_db), int'(m_db[0]));
            check("model_down_db", int'(bus.down_db), int'(m_db[1]));
            check("model_paddle_y", int'(bus.paddle_y), m_y);
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (bus.frame_tick !== 1'b1);
    endtask

    typedef struct {
        bit up;
        bit dn;
        int ticks;
        int exp_y;
    } vec_t;

    vec_t vecs[9];

    initial begin
        rst          = 1'b1;
        bus.but_up   = 1'b0;
        bus.but_down = 1'b0;

        vecs[0] = '{up: 0, dn: 0, ticks: 3,   exp_y: 208};
`ifdef PADDLE_ACCEL_EN
        vecs[1] = '{up: 1, dn: 0, ticks: 10,  exp_y: 166};
        vecs[2] = '{up: 1, dn: 1, ticks: 5,   exp_y: 166};
`else
        vecs[1] = '{up: 1, dn: 0, ticks: 10,  exp_y: 168};
        vecs[2] = '{up: 1, dn: 1, ticks: 5,   exp_y: 168};
`endif
        vecs[3] = '{up: 0, dn: 1, ticks: 70,  exp_y: 416};
        vecs[4] = '{up: 0, dn: 1, ticks: 2,   exp_y: 416};
        vecs[5] = '{up: 1, dn: 0, ticks: 1,   exp_y: 412};
        vecs[6] = '{up: 0, dn: 0, ticks: 3,   exp_y: 412};
        vecs[7] = '{up: 1, dn: 0, ticks: 110, exp_y: 0};
        vecs[8] = '{up: 1, dn: 0, ticks: 2,   exp_y: 0};

        // Reset held for two edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_paddle_y", int'(bus.paddle_y), YRST);
        check("rst_up_db", int'(bus.up_db), 0);
        check("rst_down_db", int'(bus.down_db), 0);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // A 3-cycle glitch on up is ignored.
        @(negedge clk);
        bus.but_up = 1'b1;
        repeat (3) @(negedge clk);
        bus.but_up = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("pulse_up_db", int'(bus.up_db), 0);
        end
        repeat (3) wait_tick();
        #1;
        check("pulse_paddle_y", int'(bus.paddle_y), YRST);

        // Table of held-button runs; each row continues from the previous one.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.but_up   = vecs[i].up;
            bus.but_down = vecs[i].dn;
            repeat (vecs[i].ticks) wait_tick();
            #1;
            check($sformatf("vec%0d_paddle_y", i), int'(bus.paddle_y), vecs[i].exp_y);
        end

        // Move off the edge, then reset while up is still held.
        @(negedge clk);
        bus.but_up   = 1'b0;
        bus.but_down = 1'b1;
        repeat (5) wait_tick();
        #1;
        check("pre_rst_down_y", int'(bus.paddle_y), 20);
        @(negedge clk);
        bus.but_up   = 1'b1;
        bus.but_down = 1'b0;
        repeat (4) wait_tick();
        #1;
        check("pre_rst_up_y", int'(bus.paddle_y), 4);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midhold_rst_y", int'(bus.paddle_y), YRST);
        check("midhold_rst_up_db", int'(bus.up_db), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("midhold_db_low_%0d", k), int'(bus.up_db), 0);
        end
        @(posedge clk);
        #1;
        check("midhold_db_high", int'(bus.up_db), 1);
        wait_tick();
        #1;
        check("midhold_resume_y", int'(bus.paddle_y), YRST - STEP);

        // Random button activity, glitches and occasional resets against the model.
        for (int s = 0; s < 80; s++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            bus.but_up   = 1'($urandom_range(0, 1));
            bus.but_down = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end

        bus.but_up   = 1'b0;
        bus.but_down = 1'b0;
        repeat (10) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
